// File: rtl/tr_pkg.sv
// Shared definitions for the stepper pulse generator.
// Holds the default datapath width, the default timing constants for a
// 50 MHz clk, and the state encoding of the step FSM.
// Optional feature macro used by stepgen_drv: STEPGEN_POS_COUNTER_EN.
package tr_pkg;

  localparam int WIDTH_WORK_DEF  = 16;
  localparam int PULSE_WIDTH_DEF = 50;   // 1 us step high time
  localparam int DIR_SETUP_DEF   = 25;   // 0.5 us DIR setup before STEP rise
  localparam int MIN_PERIOD_DEF  = 100;  // 2 us shortest step period
  localparam int POS_WIDTH_DEF   = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DIR_SETUP = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk     in  destination clock
//   rst     in  asynchronous active-high reset
//   async_i in  level from another clock domain
//   rise_o  out one-cycle pulse, high in the cycle after the synchronized
//               level first reads 1 (third clk edge after the input rise
//               samples it as a registered event downstream)
module pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/stepgen_drv.sv
// Stepper-motor STEP/DIR generator.
// Latches a step period from an asynchronous strobe and produces STEP pulses
// of fixed width with rising-edge spacing equal to the (clamped) period, and
// a DIR line that only changes ahead of a step by a fixed setup time.
// Optional feature macro: STEPGEN_POS_COUNTER_EN adds a signed position
// counter (pos_clr in, position out).
// Ports:
//   clk          in  system clock (50 MHz)
//   rst          in  asynchronous active-high reset
//   enable       in  motor enable
//   dir_req      in  requested direction
//   period       in  step period in clk cycles, 0 = stop
//   period_valid in  asynchronous write strobe for period
//   pos_clr      in  synchronous position clear (optional)
//   position     out signed step position (optional)
//   step         out STEP line to driver
//   dir          out DIR line to driver
//   busy         out high whenever the FSM is not idle
//
// state       | meaning
// S_IDLE      | no stepping, step low
// S_DIR_SETUP | dir just changed, waiting DIR_SETUP cycles before a step
// S_HIGH      | step high for PULSE_WIDTH cycles
// S_LOW       | step low for the remainder of cur_period
module stepgen_drv
  import tr_pkg::*;
#(
  parameter int WIDTH_WORK  = WIDTH_WORK_DEF,
  parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
  parameter int DIR_SETUP   = DIR_SETUP_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int POS_WIDTH   = POS_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        dir_req,
  input  logic [WIDTH_WORK-1:0]       period,
  input  logic                        period_valid,
`ifdef STEPGEN_POS_COUNTER_EN
  input  logic                        pos_clr,
  output logic signed [POS_WIDTH-1:0] position,
`endif
  output logic                        step,
  output logic                        dir,
  output logic                        busy
);

  // Counters load "length - 1" and leave the state when they read zero, so
  // each state lasts exactly its nominal number of cycles.
  localparam logic [WIDTH_WORK-1:0] MIN_P   = WIDTH_WORK'(MIN_PERIOD);
  localparam logic [WIDTH_WORK-1:0] PW_M1   = WIDTH_WORK'(PULSE_WIDTH - 1);
  localparam logic [WIDTH_WORK-1:0] DS_M1   = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] LOW_ADJ = WIDTH_WORK'(PULSE_WIDTH + 1);
  localparam logic [WIDTH_WORK-1:0] ONE     = WIDTH_WORK'(1);

  state_e                state_q, state_d;
  logic [WIDTH_WORK-1:0] counter_q, counter_d;
  logic [WIDTH_WORK-1:0] cur_period_q, cur_period_d;
  logic [WIDTH_WORK-1:0] period_reg_q;
  logic                  dir_q, dir_d;
  logic                  pv_rise;
  logic [WIDTH_WORK-1:0] eff_period;
  logic                  run_ok;

  pulse_sync u_pv_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (period_valid),
    .rise_o  (pv_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg_q <= '0;
    end else if (pv_rise) begin
      period_reg_q <= period;
    end
  end

  assign eff_period = (period_reg_q < MIN_P) ? MIN_P : period_reg_q;
  assign run_ok     = enable && (period_reg_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      cur_period_q <= '0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      cur_period_q <= cur_period_d;
      dir_q        <= dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    cur_period_d = cur_period_q;
    dir_d        = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_ok) begin
          if (dir_req != dir_q) begin
            state_d   = S_DIR_SETUP;
            dir_d     = dir_req;
            counter_d = DS_M1;
          end else begin
            state_d      = S_HIGH;
            counter_d    = PW_M1;
            cur_period_d = eff_period;
          end
        end
      end
      S_DIR_SETUP: begin
        if (counter_q == '0) begin
          state_d      = S_HIGH;
          counter_d    = PW_M1;
          cur_period_d = eff_period;
        end else begin
          counter_d = counter_q - ONE;
        end
      end
      S_HIGH: begin
        if (counter_q == '0) begin
          state_d   = S_LOW;
          counter_d = cur_period_q - LOW_ADJ;
        end else begin
          counter_d = counter_q - ONE;
        end
      end
      S_LOW: begin
        if (counter_q == '0) begin
          // Disable is checked first so a late dir_req never moves DIR.
          if (!run_ok) begin
            state_d = S_IDLE;
          end else if (dir_req != dir_q) begin
            state_d   = S_DIR_SETUP;
            dir_d     = dir_req;
            counter_d = DS_M1;
          end else begin
            state_d      = S_HIGH;
            counter_d    = PW_M1;
            cur_period_d = eff_period;
          end
        end else begin
          counter_d = counter_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded from the state register so reset removes a pulse immediately.
  always_comb begin
    step = (state_q == S_HIGH);
    busy = (state_q != S_IDLE);
    dir  = dir_q;
  end

`ifdef STEPGEN_POS_COUNTER_EN
  logic                 hi_entry;
  logic [POS_WIDTH-1:0] pos_q;

  assign hi_entry = (state_d == S_HIGH) && (state_q != S_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else if (pos_clr) begin
      pos_q <= '0;
    end else if (hi_entry) begin
      pos_q <= dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
    end
  end

  assign position = pos_q;
`endif

endmodule
